wbp_rr_arbiter: RTL and testbench

//  NM-port round-robin arbiter sharing one Wishbone pipelined master port
//  (e.g. a WB-classic-to-pipeline bridge output, DMA, CPU) toward a single

---
 rtl/wbp_rr_arbiter_pkg.sv | 14 +
 rtl/wbp_rr_pick.sv | 32 +++
 rtl/wbp_rr_arbiter.sv | 151 +++++++++++++++
 tb/tb_wbp_rr_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/wbp_rr_arbiter_pkg.sv
// Shared types and helpers for the Wishbone pipelined round-robin arbiter.
package wbp_rr_arbiter_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } grant_state_t;

   // Port-index width; a single-port build still needs one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wbp_rr_pick.sv
// Round-robin pick: first set request strictly after `last`, wrapping at NM.
module wbp_rr_pick
   import wbp_rr_arbiter_pkg::*;
#(
   parameter int unsigned NM = 2,
   parameter int unsigned IW = idx_w(NM)
) (
   input  logic [NM-1:0] req,
   input  logic [IW-1:0] last,
   output logic          found,
   output logic [IW-1:0] idx
);

   int unsigned k;

   // last+i never exceeds 2*NM-1, so one conditional subtract does the wrap
   always_comb begin
      found = 1'b0;
      idx   = '0;
      k     = 0;
      for (int unsigned i = 1; i <= NM; i++) begin
         k = 32'(last) + i;
         if (k >= NM)
            k = k - NM;
         if (!found && req[k]) begin
            found = 1'b1;
            idx   = IW'(k);
         end
      end
   end

endmodule

// File: rtl/wbp_rr_arbiter.sv
// NM-port round-robin arbiter onto one Wishbone pipelined master; ownership
// is per CYC and outstanding requests are counted so ACK/ERR reach the owner.
module wbp_rr_arbiter
   import wbp_rr_arbiter_pkg::*;
#(
   parameter int unsigned NM       = 2,
   parameter int unsigned AW       = 12,
   parameter int unsigned DW       = 32,
   parameter int unsigned LGMAXOUT = 4
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic [NM-1:0]        i_scyc,
   input  logic [NM-1:0]        i_sstb,
   input  logic [NM-1:0]        i_swe,
   input  logic [NM*AW-1:0]     i_saddr,
   input  logic [NM*DW-1:0]     i_sdata,
   input  logic [NM*DW/8-1:0]   i_ssel,
   output logic [NM-1:0]        o_sstall,
   output logic [NM-1:0]        o_sack,
   output logic [NM-1:0]        o_serr,
   output logic [DW-1:0]        o_sdata,
   output logic                 o_mcyc,
   output logic                 o_mstb,
   output logic                 o_mwe,
   output logic [AW-1:0]        o_maddr,
   output logic [DW-1:0]        o_mdata,
   output logic [DW/8-1:0]      o_msel,
   input  logic                 i_mstall,
   input  logic                 i_mack,
   input  logic                 i_merr,
   input  logic [DW-1:0]        i_mdata
);

   localparam int unsigned IW = idx_w(NM);
   localparam int unsigned SW = DW / 8;
   localparam int unsigned CW = LGMAXOUT;
   localparam logic [CW-1:0] CNT_MAX = '1;

   grant_state_t  state, nxt_state;
   logic [IW-1:0] owner, nxt_owner;
   logic [IW-1:0] last, nxt_last;
   logic [CW-1:0] count, nxt_count;
   logic          err_abort, nxt_err_abort;

   logic          pick_found;
   logic [IW-1:0] pick_idx;

   logic          granted;
   logic          owner_cyc;
   logic          full;
   logic          stb_acc;
   logic          ack_ok;
   logic          err_ok;
   logic          rearb;

   logic [AW-1:0] saddr_a [NM];
   logic [DW-1:0] sdata_a [NM];
   logic [SW-1:0] ssel_a  [NM];

   for (genvar g = 0; g < NM; g++) begin : g_slice
      assign saddr_a[g] = i_saddr[g*AW +: AW];
      assign sdata_a[g] = i_sdata[g*DW +: DW];
      assign ssel_a[g]  = i_ssel[g*SW +: SW];
   end

   wbp_rr_pick #(
      .NM (NM),
      .IW (IW)
   ) u_pick (
      .req   (i_scyc),
      .last  (last),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Downstream request path, muxed from the current owner
   always_comb begin
      granted   = (state == ST_GRANT);
      owner_cyc = i_scyc[owner];
      full      = (count == CNT_MAX);
      o_mcyc    = granted & owner_cyc & ~err_abort;
      o_mstb    = o_mcyc & i_sstb[owner] & ~full;
      o_mwe     = i_swe[owner];
      o_maddr   = saddr_a[owner];
      o_mdata   = sdata_a[owner];
      o_msel    = ssel_a[owner];
      o_sdata   = i_mdata;
      stb_acc   = o_mstb & ~i_mstall;
      // An ACK with nothing outstanding is stale (aborted cycle) and is dropped
      ack_ok    = o_mcyc & i_mack & (count != '0);
      err_ok    = o_mcyc & i_merr;
      rearb     = ~granted | ~owner_cyc;
   end

   // Upstream responses go only to the owner
   for (genvar g = 0; g < NM; g++) begin : g_resp
      logic own;
      assign own         = granted & (owner == IW'(g));
      assign o_sstall[g] = ~own | i_mstall | full | err_abort;
      assign o_sack[g]   = own & ack_ok;
      assign o_serr[g]   = own & err_ok;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state     <= ST_IDLE;
         owner     <= '0;
         last      <= IW'(NM - 1);
         count     <= '0;
         err_abort <= 1'b0;
      end else begin
         state     <= nxt_state;
         owner     <= nxt_owner;
         last      <= nxt_last;
         count     <= nxt_count;
         err_abort <= nxt_err_abort;
      end
   end

   // Grant FSM, outstanding counter and error-abort tracking
   always_comb begin
      nxt_state     = state;
      nxt_owner     = owner;
      nxt_last      = last;
      nxt_count     = count;
      nxt_err_abort = err_abort;

      if (rearb) begin
         nxt_count     = '0;
         nxt_err_abort = 1'b0;
         if (pick_found) begin
            nxt_state = ST_GRANT;
            nxt_owner = pick_idx;
            nxt_last  = pick_idx;
         end else begin
            nxt_state = ST_IDLE;
         end
      end else if (err_ok) begin
         nxt_count     = '0;
         nxt_err_abort = 1'b1;
      end else if (!err_abort) begin
         unique case ({stb_acc, ack_ok})
            2'b10:   nxt_count = count + CW'(1);
            2'b01:   nxt_count = count - CW'(1);
            default: nxt_count = count;
         endcase
      end
   end

endmodule

// File: tb/tb_wbp_rr_arbiter.sv
// Directed bench for wbp_rr_arbiter (NM=2, LGMAXOUT=2).
module tb_wbp_rr_arbiter;

   localparam int unsigned NM = 2;
   localparam int unsigned AW = 12;
   localparam int unsigned DW = 32;
   localparam int unsigned LG = 2;

   logic              i_clk = 1'b0;
   logic              i_reset_n;
   logic [NM-1:0]     i_scyc, i_sstb, i_swe;
   logic [NM*AW-1:0]  i_saddr;
   logic [NM*DW-1:0]  i_sdata;
   logic [NM*DW/8-1:0] i_ssel;
   logic [NM-1:0]     o_sstall, o_sack, o_serr;
   logic [DW-1:0]     o_sdata;
   logic              o_mcyc, o_mstb, o_mwe;
   logic [AW-1:0]     o_maddr;
   logic [DW-1:0]     o_mdata;
   logic [DW/8-1:0]   o_msel;
   logic              i_mstall, i_mack, i_merr;
   logic [DW-1:0]     i_mdata;

   int n_pass = 0;
   int n_tot  = 0;

   wbp_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .LGMAXOUT(LG)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n),
      .i_scyc(i_scyc), .i_sstb(i_sstb), .i_swe(i_swe),
      .i_saddr(i_saddr), .i_sdata(i_sdata), .i_ssel(i_ssel),
      .o_sstall(o_sstall), .o_sack(o_sack), .o_serr(o_serr), .o_sdata(o_sdata),
      .o_mcyc(o_mcyc), .o_mstb(o_mstb), .o_mwe(o_mwe),
      .o_maddr(o_maddr), .o_mdata(o_mdata), .o_msel(o_msel),
      .i_mstall(i_mstall), .i_mack(i_mack), .i_merr(i_merr), .i_mdata(i_mdata)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Advance one clock; inputs are then changed 1 time unit after the edge
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      i_reset_n = 1'b0;
      i_scyc = 2'b11; i_sstb = '0; i_swe = '0;
      i_saddr = '0; i_sdata = '0; i_ssel = '0;
      i_mstall = 1'b0; i_mack = 1'b0; i_merr = 1'b0; i_mdata = '0;
      i_saddr[0 +: AW]  = 12'h111;
      i_saddr[AW +: AW] = 12'h222;

      // 1: reset
      tick(); tick(); settle();
      chk("rst_mcyc",   o_mcyc,   1'b0);
      chk("rst_sstall", o_sstall, 2'b11);
      chk("rst_sack",   o_sack,   2'b00);
      chk("rst_count",  dut.count, 2'd0);
      i_reset_n = 1'b1;
      settle();
      chk("rel_mcyc0",  o_mcyc,   1'b0);
      tick(); settle();
      chk("rel_mcyc1",  o_mcyc,   1'b1);
      chk("rel_stall",  o_sstall, 2'b10);

      // 2: round robin, port 0 read
      i_sstb = 2'b01; settle();
      chk("rr0_stb",  o_mstb,  1'b1);
      chk("rr0_addr", o_maddr, 12'h111);
      chk("rr0_we",   o_mwe,   1'b0);
      tick();
      i_sstb = 2'b00; i_mack = 1'b1; i_mdata = 32'hCAFE_0001; settle();
      chk("rr0_ack",   o_sack,  2'b01);
      chk("rr0_rdata", o_sdata, 32'hCAFE_0001);
      tick();
      i_mack = 1'b0; i_scyc = 2'b10; settle();
      chk("rr0_drop", o_mcyc, 1'b0);
      tick();
      i_scyc = 2'b11; settle();
      chk("rr1_mcyc",  o_mcyc,   1'b1);
      chk("rr1_stall", o_sstall, 2'b01);
      i_sstb = 2'b10; settle();
      chk("rr1_addr", o_maddr, 12'h222);
      tick();
      i_sstb = 2'b00; i_mack = 1'b1; settle();
      chk("rr1_ack", o_sack, 2'b10);
      tick();
      i_mack = 1'b0; i_scyc = 2'b01; settle();
      chk("rr1_drop", o_mcyc, 1'b0);
      tick();
      i_scyc = 2'b11; settle();
      chk("rr2_stall", o_sstall, 2'b10);
      i_scyc = 2'b10; settle();
      chk("rr2_drop", o_mcyc, 1'b0);
      tick(); settle();
      chk("rr3_stall", o_sstall, 2'b01);

      // 3: pipelining on port 1, with a write on the first beat
      i_sstb = 2'b10; i_swe = 2'b10;
      i_sdata[DW +: DW] = 32'h1234_5678; i_ssel[4 +: 4] = 4'b0110;
      settle();
      chk("pl_we",   o_mwe,   1'b1);
      chk("pl_data", o_mdata, 32'h1234_5678);
      chk("pl_sel",  o_msel,  4'b0110);
      tick(); i_swe = 2'b00; settle();
      chk("pl_cnt1", dut.count, 2'd1);
      tick(); settle();
      chk("pl_cnt2", dut.count, 2'd2);
      chk("pl_stb3", o_mstb, 1'b1);
      tick();
      i_sstb = 2'b00; i_mack = 1'b1; settle();
      chk("pl_cnt3",  dut.count, 2'd3);
      chk("pl_full",  o_sstall, 2'b11);
      chk("pl_ack_a", o_sack, 2'b10);
      tick(); settle();
      chk("pl_cnt2b", dut.count, 2'd2);
      chk("pl_ack_b", o_sack, 2'b10);
      tick(); settle();
      chk("pl_cnt1b", dut.count, 2'd1);
      chk("pl_ack_c", o_sack, 2'b10);
      tick();
      i_mack = 1'b0; settle();
      chk("pl_cnt0", dut.count, 2'd0);
      chk("pl_noack", o_sack, 2'b00);

      // 4: full with no ACKs
      i_sstb = 2'b10;
      tick(); tick(); tick(); settle();
      chk("full_cnt",   dut.count, 2'd3);
      chk("full_stall", o_sstall,  2'b11);
      chk("full_nostb", o_mstb,    1'b0);
      i_mack = 1'b1; settle();
      chk("full_ack", o_sack, 2'b10);
      tick();
      i_mack = 1'b0; settle();
      chk("full_cnt2",  dut.count, 2'd2);
      chk("full_unst",  o_sstall,  2'b01);
      chk("full_4th",   o_mstb,    1'b1);
      tick();
      i_sstb = 2'b00; settle();
      chk("full_cnt3b", dut.count, 2'd3);
      i_mack = 1'b1;
      tick(); tick(); tick();
      i_mack = 1'b0; settle();
      chk("full_drain", dut.count, 2'd0);

      // 5: error with two outstanding, port 0 waiting
      i_scyc = 2'b11; i_sstb = 2'b10;
      tick(); tick();
      i_sstb = 2'b00; i_merr = 1'b1; settle();
      chk("err_cnt2", dut.count, 2'd2);
      chk("err_serr", o_serr, 2'b10);
      chk("err_sack", o_sack, 2'b00);
      tick();
      i_merr = 1'b0; settle();
      chk("err_cnt0", dut.count, 2'd0);
      chk("err_mcyc", o_mcyc, 1'b0);
      chk("err_serr0", o_serr, 2'b00);
      tick(); settle();
      chk("err_hold", o_mcyc, 1'b0);
      i_scyc = 2'b01;
      tick(); settle();
      chk("err_next",  o_mcyc,   1'b1);
      chk("err_nstal", o_sstall, 2'b10);

      // 6: owner aborts with two outstanding, late ACK is dropped
      i_scyc = 2'b11; i_sstb = 2'b01;
      tick(); tick();
      i_sstb = 2'b00; i_scyc = 2'b10; settle();
      chk("ab_cnt2", dut.count, 2'd2);
      chk("ab_drop", o_mcyc, 1'b0);
      tick();
      i_mack = 1'b1; settle();
      chk("ab_owner", o_sstall, 2'b01);
      chk("ab_mcyc",  o_mcyc,   1'b1);
      chk("ab_noack", o_sack,   2'b00);
      chk("ab_cnt0",  dut.count, 2'd0);
      tick();
      i_mack = 1'b0; settle();
      chk("ab_cnt0b", dut.count, 2'd0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
